pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID, ID/EXE, EXE/MEM, MEM/WB) with valid/ready
//  handshake, 2-entry skid buffer, flush and bubble insertion. Payload (rdata, imm, npc) and control
//  (opcode, alusrc, waddr, memWrite/memRead/memToReg, branch, jal, WriteEn) are separate buses.
//  Control is forced to zero whenever the stage holds no valid instruction, so a bubble never writes.
// PARAMETERS
//  DATA_W   64  payload width (concatenated data fields)
//  CTRL_W   16  control width (concatenated control fields, all active-high)
//  SKID_EN  1   1: 2-entry skid, in_ready registered; 0: single entry, in_ready combinational
//  CNT_W    16  width of stall performance counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       kill stage contents (branch/jal taken)
//  in_valid   in   1       upstream instruction valid
//  in_ready   out  1       stage can accept this cycle
//  in_data    in   DATA_W  upstream payload
//  in_ctrl    in   CTRL_W  upstream control
//  out_valid  out  1       downstream instruction valid
//  out_ready  in   1       downstream accepts (0 = stall)
//  out_data   out  DATA_W  payload to next stage
//  out_ctrl   out  CTRL_W  control to next stage; all 0 when out_valid=0
//  occupancy  out  2       entries held (0..2)
//  stall_cnt  out  CNT_W   cycles with out_valid=1 & out_ready=0, saturating
// BEHAVIOUR
//  - Reset: state EMPTY; out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0, in_ready=1
//    from first cycle after rst. rst overrides flush and all handshakes.
//  - acc = in_valid & in_ready; rel = out_valid & out_ready. Both evaluated same cycle.
//  - States (SKID_EN=1): EMPTY, ONE (main reg full), TWO (main+skid full). out_* driven by main reg.
//    EMPTY: acc -> ONE, main<=in.
//    ONE:   acc&!rel -> TWO, skid<=in; !acc&rel -> EMPTY; acc&rel -> ONE, main<=in; else hold.
//    TWO:   rel -> ONE, main<=skid; else hold. in_ready=0 in TWO (registered, = state!=TWO).
//  - SKID_EN=0: in_ready = !out_valid | out_ready; TWO unreachable; skid reg not built.
//  - Latency 1 cycle in->out from EMPTY; sustained 1 transfer/cycle; no loss, no duplication,
//    strict in-order delivery.
//  - flush (sync, priority below rst): next state EMPTY, both entries discarded, same-cycle input
//    dropped even if in_valid=1; out_valid=0, out_ctrl=0 next cycle; in_ready=1 next cycle.
//    A rel in the flush cycle still completes (downstream saw the handshake).
//  - Bubble: out_ctrl = main_ctrl & {CTRL_W{out_valid}}; out_data holds last value when invalid.
//  - stall_cnt increments when out_valid & !out_ready; saturates at all-ones; cleared only by rst.
//  - occupancy = 0/1/2 for EMPTY/ONE/TWO, registered, consistent with state.
//  - Upstream must hold in_data/in_ctrl stable while in_valid & !in_ready (assertion in bench).
// STRUCTURE
//  - Shared package/define file: state encodings PSR_EMPTY=2'd0, PSR_ONE=2'd1, PSR_TWO=2'd2;
//    default widths; control-field bit positions used by stage wrappers to pack/unpack CTRL_W.
//  - Single module; no sub-module. Stage-specific wrappers instantiate it, concatenate fields.
// TESTING
//  - Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, in_ready=1.
//  - Stream: out_ready=1, push data 0x1..0x8 back-to-back -> out_data 0x1..0x8 on consecutive
//    cycles, 1-cycle latency, occupancy stays 1.
//  - Stall/skid: push 0xA,0xB,0xC with out_ready=0 -> in_ready drops after 0xB, occupancy=2,
//    0xC held upstream; release out_ready -> 0xA,0xB,0xC delivered in order, stall_cnt=stall cycles.
//  - Flush in TWO with in_valid=1 (0xD) -> next cycle out_valid=0, out_ctrl=0, occupancy=0,
//    0xD never appears at output.
//  - Bubble: in_ctrl=16'hFFFF with in_valid=0 -> out_ctrl stays 16'h0000.
//  - SKID_EN=0 and CNT_W=2: stall 6 cycles -> in_ready follows out_ready combinationally, stall_cnt=3.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the inter-stage pipeline register: state encodings, default widths
// and the control-field layout that stage wrappers use to pack/unpack the control bus.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PSR_EMPTY = 2'd0,
        PSR_ONE   = 2'd1,
        PSR_TWO   = 2'd2
    } psr_state_e;

    localparam int PSR_DATA_W = 64;
    localparam int PSR_CTRL_W = 16;
    localparam int PSR_CNT_W  = 16;

    // Control bus layout, LSB first; every field is active-high so a zeroed bus is a bubble.
    localparam int CTRL_WRITE_EN_BIT  = 0;
    localparam int CTRL_MEM_TO_REG_BIT = 1;
    localparam int CTRL_MEM_READ_BIT  = 2;
    localparam int CTRL_MEM_WRITE_BIT = 3;
    localparam int CTRL_BRANCH_BIT    = 4;
    localparam int CTRL_JAL_BIT       = 5;
    localparam int CTRL_ALUSRC_BIT    = 6;
    localparam int CTRL_WADDR_LSB     = 7;
    localparam int CTRL_WADDR_W       = 5;
    localparam int CTRL_OPCODE_LSB    = 12;
    localparam int CTRL_OPCODE_W      = 4;

    typedef struct packed {
        logic [CTRL_OPCODE_W-1:0] opcode;
        logic [CTRL_WADDR_W-1:0]  waddr;
        logic                     alusrc;
        logic                     jal;
        logic                     branch;
        logic                     mem_write;
        logic                     mem_read;
        logic                     mem_to_reg;
        logic                     write_en;
    } psr_ctrl_t;

    function automatic logic [1:0] psr_occupancy(input psr_state_e s);
        return 2'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// flush and bubble insertion; control is masked to zero whenever the stage is empty.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W  = PSR_DATA_W,
    parameter int CTRL_W  = PSR_CTRL_W,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = PSR_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    psr_state_e        r_state;
    psr_state_e        w_next_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [1:0]        r_occ;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_acc;
    logic w_rel;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;

    assign w_out_valid = (r_state != PSR_EMPTY);
    assign w_acc       = in_valid & w_in_ready;
    assign w_rel       = w_out_valid & out_ready;

    // Flush drops both entries and the same-cycle input; a release in that cycle needs no action.
    always_comb begin
        w_next_state   = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_next_state = PSR_EMPTY;
        end else begin
            case (r_state)
                PSR_EMPTY: begin
                    if (w_acc) begin
                        w_next_state = PSR_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                PSR_ONE: begin
                    if (w_acc && w_rel) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_acc && (SKID_EN != 0)) begin
                        w_next_state = PSR_TWO;
                        w_ld_skid    = 1'b1;
                    end else if (w_rel) begin
                        w_next_state = PSR_EMPTY;
                    end
                end
                PSR_TWO: begin
                    if (w_rel) begin
                        w_next_state   = PSR_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_next_state = PSR_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= PSR_EMPTY;
            r_occ       <= 2'd0;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_occ   <= psr_occupancy(w_next_state);
            if (w_ld_main_in) begin
                r_main_data <= in_data;
                r_main_ctrl <= in_ctrl;
            end else if (w_ld_main_skid) begin
                r_main_data <= w_skid_data;
                r_main_ctrl <= w_skid_ctrl;
            end
            if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    generate
        if (SKID_EN != 0) begin : g_skid
            logic              r_in_ready;
            logic [DATA_W-1:0] r_skid_data;
            logic [CTRL_W-1:0] r_skid_ctrl;

            // Registered ready breaks the combinational path from out_ready back upstream.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_next_state != PSR_TWO);
                end
            end

            always_ff @(posedge clk) begin
                if (w_ld_skid) begin
                    r_skid_data <= in_data;
                    r_skid_ctrl <= in_ctrl;
                end
            end

            assign w_in_ready  = r_in_ready;
            assign w_skid_data = r_skid_data;
            assign w_skid_ctrl = r_skid_ctrl;
        end else begin : g_noskid
            assign w_in_ready  = ~w_out_valid | out_ready;
            assign w_skid_data = '0;
            assign w_skid_ctrl = '0;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main_data;
    assign out_ctrl  = r_main_ctrl & {CTRL_W{w_out_valid}};
    assign occupancy = r_occ;
    assign stall_cnt = r_stall_cnt;

endmodule
